// File: rtl/dark_uart_rx_if.sv
// rtl/dark_uart_rx_if.sv - received-byte stream bundle between dark_uart_rx and its consumer
//
// Purpose: carries the head-of-FIFO byte and its valid/ready handshake.
// Signals:
//   DATA  [7:0]  head-of-FIFO byte, 8'h00 whenever VALID = 0
//   VALID        FIFO not empty
//   READY        consumer accepts; a pop happens on VALID && READY
// Modports: master = receiver side, slave = consumer side.
interface dark_uart_rx_if;
  logic [7:0] DATA;
  logic       VALID;
  logic       READY;

  modport master (output DATA, output VALID, input READY);
  modport slave  (input DATA, input VALID, output READY);
endinterface

// File: rtl/dark_uart_rx.sv
// rtl/dark_uart_rx.sv - 8N1 UART receiver with oversampling FSM and FWFT byte FIFO
//
// Purpose: frames 8N1 characters from the asynchronous RXD line using a fixed
// baud divisor, buffers them in a small first-word-fall-through FIFO and
// presents them on a valid/ready byte stream.
// Ports:
//   XCLK  in   system clock, rising edge
//   XRES  in   asynchronous active-high reset
//   RXD   in   serial input, idle high, asynchronous to XCLK
//   CLR   in   synchronous clear of FERR / OVF (a same-cycle set wins)
//   FERR  out  sticky framing error
//   OVF   out  sticky overflow (byte dropped)
//   bus   master side of dark_uart_rx_if (DATA / VALID / READY)
module dark_uart_rx #(
  parameter int BAUD_DIV   = 868,
  parameter int FIFO_DEPTH = 4
) (
  input  logic XCLK,
  input  logic XRES,
  input  logic RXD,
  input  logic CLR,
  output logic FERR,
  output logic OVF,
  dark_uart_rx_if.master bus
);

  localparam int HALF = BAUD_DIV >> 1;
  localparam int CW   = $clog2(BAUD_DIV);
  localparam int AW   = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_BIT  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  // Two-flop synchronizer; rxs_q is the synchronized line, rxs_prev_q its
  // one-cycle-delayed copy used only for falling-edge detection.
  logic sync1_q;
  logic rxs_q;
  logic rxs_prev_q;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bitn_q, bitn_d;
  logic [7:0]    sh_q, sh_d;
  logic          ferr_q, ferr_d;
  logic          ovf_q, ovf_d;
  logic [AW:0]   wp_q, wp_d;
  logic [AW:0]   rp_q, rp_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic fall;
  logic tick;
  logic push;
  logic frame_err;
  logic empty;
  logic full;
  logic pop;
  logic wr_en;
  logic drop;

  assign fall = rxs_prev_q & ~rxs_q;
  assign tick = (cnt_q == '0);

  // Frame FSM: cnt counts down to the centre of each bit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bitn_d    = bitn_q;
    sh_d      = sh_q;
    push      = 1'b0;
    frame_err = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fall) begin
          cnt_d   = CNT_HALF;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          if (!rxs_q) begin
            cnt_d   = CNT_BIT;
            bitn_d  = 3'd0;
            state_d = S_DATA;
          end else begin
            // Line already back high at mid-start: treat as a glitch.
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DATA: begin
        if (tick) begin
          sh_d[bitn_q] = rxs_q;
          cnt_d        = CNT_BIT;
          if (bitn_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bitn_d = bitn_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (rxs_q) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_err = 1'b1;
            state_d   = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_BREAK: begin
        // Hold off start detection until the line has returned high.
        if (rxs_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO: the extra pointer bit separates full from empty. A push into a
  // full FIFO is still accepted when a pop frees the head in the same cycle.
  always_comb begin
    empty = (wp_q == rp_q);
    full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    pop   = !empty && bus.READY;
    wr_en = push && (!full || pop);
    drop  = push && full && !pop;

    wp_d = wp_q;
    rp_d = rp_q;
    if (wr_en) begin
      wp_d = wp_q + PTR_ONE;
    end
    if (pop) begin
      rp_d = rp_q + PTR_ONE;
    end

    // Set takes priority over clear.
    ferr_d = ferr_q;
    if (frame_err) begin
      ferr_d = 1'b1;
    end else if (CLR) begin
      ferr_d = 1'b0;
    end

    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (CLR) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge XCLK or posedge XRES) begin
    if (XRES) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bitn_q     <= 3'd0;
      sh_q       <= 8'h00;
      ferr_q     <= 1'b0;
      ovf_q      <= 1'b0;
      wp_q       <= '0;
      rp_q       <= '0;
    end else begin
      sync1_q    <= RXD;
      rxs_q      <= sync1_q;
      rxs_prev_q <= rxs_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitn_q     <= bitn_d;
      sh_q       <= sh_d;
      ferr_q     <= ferr_d;
      ovf_q      <= ovf_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
    end
  end

  // Storage needs no reset: DATA is masked to zero while the FIFO is empty.
  always_ff @(posedge XCLK) begin
    if (wr_en) begin
      mem_q[wp_q[AW-1:0]] <= sh_q;
    end
  end

  assign bus.VALID = !empty;
  assign bus.DATA  = empty ? 8'h00 : mem_q[rp_q[AW-1:0]];
  assign FERR      = ferr_q;
  assign OVF       = ovf_q;

endmodule
